clk_monitor: RTL and testbench



---
 rtl/clk_monitor.sv | 166 ++++++++++++++++
 tb/tb_clk_monitor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_monitor.sv
// clk_monitor: counts synchronized rising edges of mon_in over fixed clk gate windows and
// debounces an in-range lock status. Define CLK_MONITOR_STUCK_EN to add the static-input detector.
module clk_monitor #(
  parameter int WINDOW  = 1024,
  parameter int CNT_W   = 16,
  parameter int EXP_MIN = 120,
  parameter int EXP_MAX = 136,
  parameter int GOOD_N  = 4,
  parameter int BAD_N   = 2
`ifdef CLK_MONITOR_STUCK_EN
  ,
  parameter int STUCK_CYCLES = 256
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mon_in,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             in_range,
  output logic             locked,
  output logic [7:0]       fail_cnt,
  output logic             stuck
);
  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int GR_W  = $clog2(GOOD_N + 1);
  localparam int BR_W  = $clog2(BAD_N + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [GR_W-1:0]  GOOD_SAT = GR_W'(GOOD_N);
  localparam logic [BR_W-1:0]  BAD_SAT  = BR_W'(BAD_N);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, MEASURE = 2'd1, EVAL = 2'd2} state_t;

  state_t           state_r;
  logic             s1_r, s2_r, s3_r;
  logic [WIN_W-1:0] win_cnt_r;
  logic [CNT_W-1:0] edge_cnt_r;
  logic [GR_W-1:0]  good_run_r;
  logic [BR_W-1:0]  bad_run_r;
  logic             edge_s, last_s, win_in_range_s;
  logic             stuck_hit_s, stuck_hold_s;
  logic [CNT_W-1:0] edge_cnt_nx_s;
  logic [31:0]      cnt_ext_s;

  // Synchronizer plus edge-detect stage for the asynchronous monitored input
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= mon_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Window result as it stands including this cycle's edge, so the terminal-cycle edge is counted
  always_comb begin
    edge_s = s2_r & ~s3_r;
    last_s = (win_cnt_r == WIN_LAST);
    if (edge_s && (edge_cnt_r != CNT_MAX)) begin
      edge_cnt_nx_s = edge_cnt_r + CNT_W'(1'b1);
    end else begin
      edge_cnt_nx_s = edge_cnt_r;
    end
    cnt_ext_s      = 32'(edge_cnt_nx_s);
    win_in_range_s = (cnt_ext_s >= 32'(EXP_MIN)) && (cnt_ext_s <= 32'(EXP_MAX));
  end

`ifdef CLK_MONITOR_STUCK_EN
  localparam int QC_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [QC_W-1:0] QUIET_SAT = QC_W'(STUCK_CYCLES);

  logic [QC_W-1:0] quiet_cnt_r;
  logic            s2_change_s;

  assign s2_change_s  = s2_r ^ s3_r;
  assign stuck_hit_s  = en & ~s2_change_s & (quiet_cnt_r == (QUIET_SAT - QC_W'(1'b1)));
  assign stuck_hold_s = stuck;

  // Quiet-time counter: restarts on each synchronized transition, flags stuck on reaching the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      quiet_cnt_r <= '0;
      stuck       <= 1'b0;
    end else if (!en || s2_change_s) begin
      quiet_cnt_r <= '0;
      stuck       <= 1'b0;
    end else if (quiet_cnt_r != QUIET_SAT) begin
      quiet_cnt_r <= quiet_cnt_r + QC_W'(1'b1);
      if (stuck_hit_s) begin
        stuck <= 1'b1;
      end
    end
  end
`else
  assign stuck_hit_s  = 1'b0;
  assign stuck_hold_s = 1'b0;
  assign stuck        = 1'b0;
`endif

  // Gate-window FSM, result registers and lock debounce
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      win_cnt_r   <= '0;
      edge_cnt_r  <= '0;
      good_run_r  <= '0;
      bad_run_r   <= '0;
      count       <= '0;
      count_valid <= 1'b0;
      in_range    <= 1'b0;
      locked      <= 1'b0;
      fail_cnt    <= 8'd0;
    end else begin
      count_valid <= 1'b0;
      if (!en) begin
        // Abort: results and fail history survive, the partial window and lock state do not
        state_r    <= IDLE;
        win_cnt_r  <= '0;
        edge_cnt_r <= '0;
        good_run_r <= '0;
        bad_run_r  <= '0;
        locked     <= 1'b0;
      end else begin
        case (state_r)
          IDLE, EVAL: begin
            state_r    <= MEASURE;
            win_cnt_r  <= '0;
            edge_cnt_r <= '0;
          end
          MEASURE: begin
            win_cnt_r  <= win_cnt_r + WIN_W'(1'b1);
            edge_cnt_r <= edge_cnt_nx_s;
            if (last_s) begin
              state_r     <= EVAL;
              count       <= edge_cnt_nx_s;
              in_range    <= win_in_range_s;
              count_valid <= 1'b1;
              if (win_in_range_s) begin
                bad_run_r <= '0;
                if (good_run_r != GOOD_SAT) good_run_r <= good_run_r + GR_W'(1'b1);
              end else begin
                good_run_r <= '0;
                if (bad_run_r != BAD_SAT) bad_run_r <= bad_run_r + BR_W'(1'b1);
                if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
              end
            end
          end
          default: state_r <= IDLE;
        endcase
        if (stuck_hit_s || stuck_hold_s) begin
          locked     <= 1'b0;
          good_run_r <= '0;
        end else if (good_run_r == GOOD_SAT) begin
          locked <= 1'b1;
        end else if (bad_run_r == BAD_SAT) begin
          locked <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_clk_monitor.sv
// Self-checking bench for clk_monitor: a window-level reference model computes edge counts from
// the recorded mon_in history and tracks the lock/fail rules window by window.
module tb_clk_monitor;
  localparam int W = 64;

  logic        clk, rst, en, mon_in, mon_sat;
  logic [15:0] count;
  logic        count_valid, in_range, locked, stuck;
  logic [7:0]  fail_cnt;
  logic [3:0]  sat_count;
  logic        sat_valid, sat_in_range, sat_locked, sat_stuck;
  logic [7:0]  sat_fail;

  clk_monitor #(
    .WINDOW(W), .CNT_W(16), .EXP_MIN(15), .EXP_MAX(17), .GOOD_N(4), .BAD_N(2)
`ifdef CLK_MONITOR_STUCK_EN
    , .STUCK_CYCLES(20)
`endif
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .mon_in(mon_in),
    .count(count), .count_valid(count_valid), .in_range(in_range),
    .locked(locked), .fail_cnt(fail_cnt), .stuck(stuck)
  );

  clk_monitor #(.WINDOW(W), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .en(en), .mon_in(mon_sat),
    .count(sat_count), .count_valid(sat_valid), .in_range(sat_in_range),
    .locked(sat_locked), .fail_cnt(sat_fail), .stuck(sat_stuck)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit hist [0:16383];
  int per = 4;
  int ph = 0;
  bit hold_low = 1'b0;
  int ws = 0;
  int gr = 0, br = 0, fails = 0, sfails = 0;
  bit lk = 1'b0;
  int last_count = 0;
  bit last_ir = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: record what the DUT samples at the edge, then move the inputs at the falling edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    hist[cyc] = rst ? 1'b0 : mon_in;
    if (rst && cyc >= 2) begin
      hist[cyc-1] = 1'b0;
      hist[cyc-2] = 1'b0;
    end
    @(negedge clk);
    ph++;
    mon_in  = hold_low ? 1'b0 : ((ph % per) < (per / 2));
    mon_sat = ~mon_sat;
  endtask

  // Runs to the end of the window whose first counting edge is ws and checks it against the model.
  task automatic run_window(input string tag);
    int g, n;
    bit ir;
    g = 0;
    while (count_valid !== 1'b1 && g < 3 * W) begin
      step();
      g++;
    end
    chk({tag, "_valid_cyc"}, cyc, ws + W - 1);
    n = 0;
    for (int j = ws; j < ws + W; j++) begin
      if (hist[j-2] && !hist[j-3]) n++;
    end
    if (n > 65535) n = 65535;
    ir = (n >= 15) && (n <= 17);
    chk({tag, "_count"}, count, n);
    chk({tag, "_in_range"}, in_range, ir);
    if (ir) begin
      gr = (gr < 4) ? gr + 1 : 4;
      br = 0;
    end else begin
      br = (br < 2) ? br + 1 : 2;
      gr = 0;
      if (fails < 255) fails++;
    end
    chk({tag, "_fail_cnt"}, fail_cnt, fails);
    chk({tag, "_locked_eval"}, locked, lk);
    chk({tag, "_stuck"}, stuck, 1'b0);
    chk({tag, "_sat_valid"}, sat_valid, 1'b1);
    chk({tag, "_sat_count"}, sat_count, 15);
    chk({tag, "_sat_in_range"}, sat_in_range, 1'b0);
    if (sfails < 255) sfails++;
    chk({tag, "_sat_fail"}, sat_fail, sfails);
    last_count = n;
    last_ir = ir;
    step();
    chk({tag, "_valid_pulse"}, count_valid, 1'b0);
    if (gr == 4) lk = 1'b1;
    else if (br == 2) lk = 1'b0;
    chk({tag, "_locked"}, locked, lk);
    chk({tag, "_sat_locked"}, sat_locked, 1'b0);
    ws = ws + W + 1;
  endtask

  initial begin
    int g;
    int kk;
    bit seen;
    clk = 1'b0; rst = 1'b1; en = 1'b0; mon_in = 1'b0; mon_sat = 1'b0;

    // Reset state
    repeat (4) step();
    chk("rst_count", count, 0);
    chk("rst_valid", count_valid, 1'b0);
    chk("rst_in_range", in_range, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_fail", fail_cnt, 0);
    chk("rst_stuck", stuck, 1'b0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_sat_stuck", sat_stuck, 1'b0);
    rst = 1'b0;

    // Lock acquire at period 4
    ph = $urandom_range(0, 7);
    repeat ($urandom_range(1, 5)) step();
    en = 1'b1;
    ws = cyc + 2;
    for (int w = 0; w < 4; w++) run_window("acq");
    chk("acq_locked_final", locked, 1'b1);
    chk("acq_fail_zero", fail_cnt, 0);

    // Loss of lock at period 8
    per = 8;
    run_window("loss1");
    chk("loss1_still_locked", locked, 1'b1);
    run_window("loss2");
    chk("loss2_unlocked", locked, 1'b0);
    chk("loss_fail2", fail_cnt, 2);

    // Relock, then abort mid-window
    per = 4;
    for (int w = 0; w < 7 && !lk; w++) run_window("relock");
    chk("relock_locked", locked, 1'b1);
    while (cyc < ws + 29) step();
    en = 1'b0;
    step();
    chk("abort_locked", locked, 1'b0);
    chk("abort_valid", count_valid, 1'b0);
    gr = 0; br = 0; lk = 1'b0;
    seen = 1'b0;
    repeat (W + 5) begin
      step();
      if (count_valid || sat_valid) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 1'b0);
    chk("abort_count_kept", count, last_count);
    chk("abort_in_range_kept", in_range, last_ir);
    chk("abort_fail_kept", fail_cnt, fails);
    en = 1'b1;
    ws = cyc + 2;
    run_window("reen");
    chk("reen_count16", count, 16);

    // Mid-window reset while locked
    for (int w = 0; w < 6 && !lk; w++) run_window("prerst");
    chk("prerst_locked", locked, 1'b1);
    while (cyc < ws + 10) step();
    rst = 1'b1;
    en = 1'b0;
    step();
    chk("mrst_count", count, 0);
    chk("mrst_valid", count_valid, 1'b0);
    chk("mrst_in_range", in_range, 1'b0);
    chk("mrst_locked", locked, 1'b0);
    chk("mrst_fail", fail_cnt, 0);
    chk("mrst_sat_fail", sat_fail, 0);
    rst = 1'b0;
    gr = 0; br = 0; lk = 1'b0; fails = 0; sfails = 0;
    repeat (3) step();

`ifdef CLK_MONITOR_STUCK_EN
    // Static input while locked
    en = 1'b1;
    ws = cyc + 2;
    for (int w = 0; w < 4; w++) run_window("stk_acq");
    while (cyc < ws + 5) step();
    hold_low = 1'b1;
    g = 0;
    while (stuck !== 1'b1 && g < 100) begin
      step();
      g++;
    end
    kk = 0;
    for (int k = cyc; k > 3; k--) begin
      if (hist[k] != hist[k-1]) begin
        kk = k;
        break;
      end
    end
    chk("stuck_time", cyc, kk + 22);
    chk("stuck_locked", locked, 1'b0);
    gr = 0; lk = 1'b0;
    hold_low = 1'b0;
    g = 0;
    while (stuck !== 1'b0 && g < 30) begin
      step();
      g++;
    end
    chk("stuck_cleared", stuck, 1'b0);
    run_window("stk_win");
    for (int w = 0; w < 4; w++) run_window("stk_relock");
    chk("stk_relocked", locked, 1'b1);
    en = 1'b0;
    repeat (3) step();
    gr = 0; br = 0; lk = 1'b0;
`endif

    // Randomized periods, one per window
    ph = $urandom_range(0, 15);
    repeat ($urandom_range(1, 5)) step();
    en = 1'b1;
    ws = cyc + 2;
    for (int w = 0; w < 6; w++) begin
      per = $urandom_range(3, 9);
      run_window("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
